// File: rtl/edge_adder_cfg_sequencer_pkg.sv
// Shared constants, state encoding and command codes for the edge adder
// configuration sequencer.
package edge_seq_pkg;

    localparam int unsigned NUM_SW    = 8;
    localparam int unsigned SEL_IN    = 2;
    localparam int unsigned CFG_DEPTH = 16;
    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned CNT_W     = 8;

    // Per-switch field {add_en, cmd[2:0], sel[SEL_IN-1:0]}, sel in the LSBs.
    localparam int unsigned SW_W       = 4 + SEL_IN;
    localparam int unsigned SEL_OFF    = 0;
    localparam int unsigned CMD_OFF    = SEL_IN;
    localparam int unsigned ADD_EN_OFF = SEL_IN + 3;

    // Entry layout: switch fields in the low bits, beat count in the MSBs.
    localparam int unsigned SWF_W   = NUM_SW * SW_W;
    localparam int unsigned ENTRY_W = SWF_W + CNT_W;
    localparam int unsigned CNT_MSB = ENTRY_W - 1;

    localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W + 1)'(CFG_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    localparam logic [2:0] CMD_NA    = 3'b000;
    localparam logic [2:0] CMD_ADD   = 3'b010;
    localparam logic [2:0] CMD_VN_L  = 3'b011;
    localparam logic [2:0] CMD_VN_R  = 3'b100;
    localparam logic [2:0] CMD_VN_LR = 3'b101;

    // Only the virtual-neuron commands present data to the switch.
    function automatic logic cmd_is_vn(input logic [2:0] c);
        return (c == CMD_VN_L) || (c == CMD_VN_R) || (c == CMD_VN_LR);
    endfunction

endpackage

// File: rtl/edge_adder_cfg_sequencer_if.sv
// Controller-side bus of the sequencer: config write port, start/stall
// controls, status and the per-switch drive signals.
interface edge_adder_cfg_sequencer_if;
    import edge_seq_pkg::*;

    logic                       i_cfg_we;
    logic [ADDR_W-1:0]          i_cfg_addr;
    logic [ENTRY_W-1:0]         i_cfg_data;
    logic                       i_start;
    logic [ADDR_W:0]            i_num_entries;
    logic                       i_stall;
    logic                       o_busy;
    logic                       o_done;
    logic                       o_cfg_err;
    logic [NUM_SW-1:0]          o_sw_valid;
    logic [NUM_SW-1:0]          o_sw_add_en;
    logic [3*NUM_SW-1:0]        o_sw_cmd;
    logic [SEL_IN*NUM_SW-1:0]   o_sw_sel;
    logic [15:0]                o_beat_cnt;

    modport master (
        output i_cfg_we, i_cfg_addr, i_cfg_data, i_start, i_num_entries, i_stall,
        input  o_busy, o_done, o_cfg_err, o_sw_valid, o_sw_add_en, o_sw_cmd,
               o_sw_sel, o_beat_cnt
    );

    modport slave (
        input  i_cfg_we, i_cfg_addr, i_cfg_data, i_start, i_num_entries, i_stall,
        output o_busy, o_done, o_cfg_err, o_sw_valid, o_sw_add_en, o_sw_cmd,
               o_sw_sel, o_beat_cnt
    );

endinterface

// File: rtl/edge_adder_cfg_sequencer_ram.sv
// Schedule storage: one write port, one registered read port. A read that
// hits the address being written in the same cycle returns the new data.
module edge_cfg_ram
    import edge_seq_pkg::*;
(
    input  logic               clk,
    input  logic               we_i,
    input  logic [ADDR_W-1:0]  waddr_i,
    input  logic [ENTRY_W-1:0] wdata_i,
    input  logic               re_i,
    input  logic [ADDR_W-1:0]  raddr_i,
    output logic [ENTRY_W-1:0] rdata_o
);

    logic [ENTRY_W-1:0] mem_q [CFG_DEPTH];
    logic [ENTRY_W-1:0] rdata_q;

    // Storage write.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read with write-to-read forwarding.
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/edge_adder_cfg_sequencer.sv
// Replays the stored schedule of switch configurations, issuing beats with
// valid/add_en in the beat cycle and cmd/sel one cycle later.
module edge_adder_cfg_sequencer
    import edge_seq_pkg::*;
(
    input logic                       clk,
    input logic                       rst,
    edge_adder_cfg_sequencer_if.slave bus
);

    state_e                    state_q, state_d;
    logic [ADDR_W-1:0]         ptr_q, ptr_d, last_q, last_d;
    logic [CNT_W-1:0]          left_q, left_d;
    logic [SWF_W-1:0]          work_q, work_d;
    logic                      issue, zero_done, start_run, rd_en, wr_ok;
    logic [ENTRY_W-1:0]        rd_data;
    logic [CNT_W-1:0]          rd_cnt;
    logic [NUM_SW-1:0]         vn_mask, add_mask;
    logic [3*NUM_SW-1:0]       cmd_w;
    logic [SEL_IN*NUM_SW-1:0]  sel_w;

    logic                      busy_q, done_q, err_q, beat_q;
    logic [NUM_SW-1:0]         valid_q, add_en_q;
    logic [3*NUM_SW-1:0]       cmd_q;
    logic [SEL_IN*NUM_SW-1:0]  sel_q;
    logic [15:0]               cnt_q;

    assign wr_ok  = bus.i_cfg_we && (state_q == S_IDLE);
    assign rd_en  = (state_d == S_LOAD);
    assign rd_cnt = rd_data[CNT_MSB -: CNT_W];

    // The read is launched on the edge entering LOAD, so LOAD sees entry[ptr].
    edge_cfg_ram u_ram (
        .clk     (clk),
        .we_i    (wr_ok),
        .waddr_i (bus.i_cfg_addr),
        .wdata_i (bus.i_cfg_data),
        .re_i    (rd_en),
        .raddr_i (ptr_d),
        .rdata_o (rd_data)
    );

    // Next-state logic: schedule walk and beat issue decision.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        last_d    = last_q;
        left_d    = left_q;
        work_d    = work_q;
        issue     = 1'b0;
        zero_done = 1'b0;
        start_run = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    if (bus.i_num_entries == '0) begin
                        zero_done = 1'b1;
                    end else begin
                        start_run = 1'b1;
                        state_d   = S_LOAD;
                        ptr_d     = '0;
                        last_d    = (bus.i_num_entries > DEPTH_N) ? ADDR_W'(CFG_DEPTH - 1)
                                                                  : ADDR_W'(bus.i_num_entries - 1'b1);
                    end
                end
            end
            S_LOAD: begin
                work_d = rd_data[SWF_W-1:0];
                left_d = rd_cnt;
                if (rd_cnt != '0) begin
                    state_d = S_RUN;
                end else if (ptr_q == last_q) begin
                    state_d = S_DRAIN;
                end else begin
                    ptr_d   = ptr_q + 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_RUN: begin
                if (!bus.i_stall) begin
                    issue  = 1'b1;
                    left_d = left_q - 1'b1;
                    if (left_q == CNT_W'(1)) begin
                        if (ptr_q == last_q) begin
                            state_d = S_DRAIN;
                        end else begin
                            ptr_d   = ptr_q + 1'b1;
                            state_d = S_LOAD;
                        end
                    end
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Unpack the working entry into per-switch drive vectors.
    always_comb begin
        vn_mask  = '0;
        add_mask = '0;
        cmd_w    = '0;
        sel_w    = '0;
        for (int unsigned k = 0; k < NUM_SW; k++) begin
            cmd_w[k*3 +: 3]           = work_q[k*SW_W + CMD_OFF +: 3];
            sel_w[k*SEL_IN +: SEL_IN] = work_q[k*SW_W + SEL_OFF +: SEL_IN];
            add_mask[k]               = work_q[k*SW_W + ADD_EN_OFF];
            vn_mask[k]                = cmd_is_vn(work_q[k*SW_W + CMD_OFF +: 3]);
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            last_q  <= '0;
            left_q  <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            last_q  <= last_d;
            left_q  <= left_d;
            work_q  <= work_d;
        end
    end

    // Output registers; cmd/sel trail the beat by one cycle and clear after DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            beat_q   <= 1'b0;
            valid_q  <= '0;
            add_en_q <= '0;
            cmd_q    <= '0;
            sel_q    <= '0;
            cnt_q    <= '0;
        end else begin
            busy_q   <= (state_d != S_IDLE);
            done_q   <= zero_done || (state_q == S_DONE);
            err_q    <= bus.i_cfg_we && (state_q != S_IDLE);
            beat_q   <= issue;
            valid_q  <= issue ? vn_mask : '0;
            add_en_q <= issue ? add_mask : '0;
            if (state_q == S_DONE) begin
                cmd_q <= '0;
                sel_q <= '0;
            end else if (beat_q) begin
                cmd_q <= cmd_w;
                sel_q <= sel_w;
            end
            if (start_run) begin
                cnt_q <= '0;
            end else if (issue && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.o_busy      = busy_q;
    assign bus.o_done      = done_q;
    assign bus.o_cfg_err   = err_q;
    assign bus.o_sw_valid  = valid_q;
    assign bus.o_sw_add_en = add_en_q;
    assign bus.o_sw_cmd    = cmd_q;
    assign bus.o_sw_sel    = sel_q;
    assign bus.o_beat_cnt  = cnt_q;

endmodule

// File: tb/tb_edge_adder_cfg_sequencer.sv
// Bench for edge_adder_cfg_sequencer: directed schedules plus random ones,
// each checked cycle by cycle against a timeline predicted from the schedule.
module tb_edge_adder_cfg_sequencer;
    import edge_seq_pkg::*;

    localparam int MAXC = 400;

    typedef struct packed {
        logic [7:0]  cnt;
        logic [7:0]  add_en;
        logic [23:0] cmd;
        logic [15:0] sel;
    } entry_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    edge_adder_cfg_sequencer_if bus();
    edge_adder_cfg_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

    entry_t      mdl [16];
    int          n_vec = 0;
    int          n_err = 0;
    bit          stall_v [MAXC];
    logic [7:0]  e_valid [MAXC];
    logic [7:0]  e_add   [MAXC];
    logic [23:0] e_cmd   [MAXC];
    logic [15:0] e_sel   [MAXC];
    logic [15:0] e_cnt   [MAXC];
    logic        e_busy  [MAXC];
    logic        e_done  [MAXC];
    int          last_c;

    task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, c, obs, exp);
        end
    endtask

    function automatic logic [ENTRY_W-1:0] pack(input entry_t e);
        logic [ENTRY_W-1:0] d;
        d = '0;
        for (int k = 0; k < 8; k++)
            d[k*SW_W +: SW_W] = {e.add_en[k], e.cmd[k*3 +: 3], e.sel[k*2 +: 2]};
        d[ENTRY_W-1 -: CNT_W] = e.cnt;
        return d;
    endfunction

    function automatic logic [7:0] vn_of(input entry_t e);
        logic [7:0] m;
        logic [2:0] c;
        for (int k = 0; k < 8; k++) begin
            c    = e.cmd[k*3 +: 3];
            m[k] = (c >= 3'd3) && (c <= 3'd5);
        end
        return m;
    endfunction

    function automatic entry_t rand_entry(input int maxc);
        entry_t e;
        e.cnt    = 8'($urandom_range(0, maxc));
        e.add_en = 8'($urandom);
        e.cmd    = 24'($urandom);
        e.sel    = 16'($urandom);
        return e;
    endfunction

    function automatic void clear_stall();
        for (int x = 0; x < MAXC; x++) stall_v[x] = 1'b0;
    endfunction

    // Predict every output per cycle from the list of beats the schedule yields.
    // Cycle 0 is the first cycle after the start edge.
    function automatic void build(input int n_req);
        int n, c, rem, done_c;
        int bc[$];
        int be[$];
        n = (n_req > 16) ? 16 : n_req;
        c = 0;
        for (int i = 0; i < n; i++) begin
            rem = int'(mdl[i].cnt);
            c++;
            while (rem > 0 && c < MAXC - 8) begin
                if (!stall_v[c]) begin
                    bc.push_back(c);
                    be.push_back(i);
                    rem--;
                end
                c++;
            end
        end
        done_c = c + 2;
        last_c = c + 3;
        for (int x = 0; x < MAXC; x++) begin
            e_valid[x] = '0; e_add[x] = '0; e_cmd[x] = '0; e_sel[x] = '0; e_cnt[x] = '0;
            e_busy[x]  = (x <= c + 1);
            e_done[x]  = (x == done_c);
        end
        for (int b = 0; b < bc.size(); b++) begin
            e_valid[bc[b]+1] = vn_of(mdl[be[b]]);
            e_add[bc[b]+1]   = mdl[be[b]].add_en;
            for (int x = bc[b] + 1; x < MAXC; x++) e_cnt[x] = e_cnt[x] + 16'd1;
            for (int x = bc[b] + 2; x < done_c; x++) begin
                e_cmd[x] = mdl[be[b]].cmd;
                e_sel[x] = mdl[be[b]].sel;
            end
        end
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 0, 32'(bus.o_sw_valid), 0);
        chk({tag, "_add"},   0, 32'(bus.o_sw_add_en), 0);
        chk({tag, "_cmd"},   0, 32'(bus.o_sw_cmd), 0);
        chk({tag, "_sel"},   0, 32'(bus.o_sw_sel), 0);
        chk({tag, "_busy"},  0, 32'(bus.o_busy), 0);
        chk({tag, "_done"},  0, 32'(bus.o_done), 0);
        chk({tag, "_err"},   0, 32'(bus.o_cfg_err), 0);
        chk({tag, "_cnt"},   0, 32'(bus.o_beat_cnt), 0);
    endtask

    task automatic cfg_write(input int a);
        bus.i_cfg_we   = 1'b1;
        bus.i_cfg_addr = 4'(a);
        bus.i_cfg_data = pack(mdl[a]);
        @(posedge clk); #1;
        bus.i_cfg_we = 1'b0;
        @(negedge clk);
        chk("idle_wr_err", 0, 32'(bus.o_cfg_err), 0);
        @(posedge clk); #1;
    endtask

    // Start a run and check all outputs each cycle. cw writes mdl[0] in the
    // start cycle; wr_c injects a dropped write plus a stray start mid-run.
    task automatic run(input string tag, input int n_req, input int wr_c, input bit cw);
        build(n_req);
        bus.i_start       = 1'b1;
        bus.i_num_entries = 5'(n_req);
        if (cw) begin
            bus.i_cfg_we   = 1'b1;
            bus.i_cfg_addr = 4'd0;
            bus.i_cfg_data = pack(mdl[0]);
        end
        @(posedge clk); #1;
        bus.i_start  = 1'b0;
        bus.i_cfg_we = 1'b0;
        for (int c = 0; c <= last_c; c++) begin
            bus.i_stall = stall_v[c];
            if (c == wr_c) begin
                bus.i_cfg_we      = 1'b1;
                bus.i_cfg_addr    = 4'd0;
                bus.i_cfg_data    = ~pack(mdl[0]);
                bus.i_start       = 1'b1;
                bus.i_num_entries = 5'd1;
            end
            @(negedge clk);
            chk({tag, "_valid"}, c, 32'(bus.o_sw_valid), 32'(e_valid[c]));
            chk({tag, "_add"},   c, 32'(bus.o_sw_add_en), 32'(e_add[c]));
            chk({tag, "_cmd"},   c, 32'(bus.o_sw_cmd), 32'(e_cmd[c]));
            chk({tag, "_sel"},   c, 32'(bus.o_sw_sel), 32'(e_sel[c]));
            chk({tag, "_busy"},  c, 32'(bus.o_busy), 32'(e_busy[c]));
            chk({tag, "_done"},  c, 32'(bus.o_done), 32'(e_done[c]));
            chk({tag, "_cnt"},   c, 32'(bus.o_beat_cnt), 32'(e_cnt[c]));
            chk({tag, "_err"},   c, 32'(bus.o_cfg_err), 32'(c == wr_c + 1 && wr_c >= 0));
            @(posedge clk); #1;
            bus.i_cfg_we = 1'b0;
            bus.i_start  = 1'b0;
        end
        bus.i_stall = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        bus.i_cfg_we = 1'b0; bus.i_cfg_addr = '0; bus.i_cfg_data = '0;
        bus.i_start = 1'b0; bus.i_num_entries = '0; bus.i_stall = 1'b0;
        clear_stall();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        #1 rst = 1'b1;
        @(posedge clk); #1;

        for (int a = 0; a < 16; a++) begin
            mdl[a] = rand_entry(3);
            cfg_write(a);
        end

        // Basic two-entry run; entry 0 is rewritten in the start cycle.
        mdl[1] = '{cnt: 8'd2, add_en: 8'h00, cmd: {8{CMD_VN_L}}, sel: 16'h1B1B};
        cfg_write(1);
        mdl[0] = '{cnt: 8'd3, add_en: 8'h00, cmd: {8{CMD_VN_LR}}, sel: 16'hE4E4};
        run("basic", 2, -1, 1'b1);
        chk("basic_total", 0, 32'(bus.o_beat_cnt), 5);

        // Masking: switch 0 is an add, the rest are right-VN commands.
        mdl[0] = '{cnt: 8'd1, add_en: 8'h01, cmd: {{7{CMD_VN_R}}, CMD_ADD}, sel: 16'h5555};
        cfg_write(0);
        run("mask", 1, -1, 1'b0);

        // Two-cycle stall after the second beat.
        mdl[0] = rand_entry(0);
        mdl[0].cnt = 8'd4;
        cfg_write(0);
        stall_v[3] = 1'b1;
        stall_v[4] = 1'b1;
        run("stall", 1, -1, 1'b0);
        chk("stall_total", 0, 32'(bus.o_beat_cnt), 4);
        clear_stall();

        // Zero-entry start completes without going busy.
        bus.i_start = 1'b1;
        bus.i_num_entries = 5'd0;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        @(negedge clk);
        chk("zero_done", 0, 32'(bus.o_done), 1);
        chk("zero_busy", 0, 32'(bus.o_busy), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("zero_done_clr", 1, 32'(bus.o_done), 0);
        @(posedge clk); #1;

        // Zero-count entries are skipped.
        mdl[0] = rand_entry(0); mdl[0].cnt = 8'd0; cfg_write(0);
        mdl[1] = rand_entry(0); mdl[1].cnt = 8'd2; cfg_write(1);
        mdl[2] = rand_entry(0); mdl[2].cnt = 8'd0; cfg_write(2);
        run("skip", 3, -1, 1'b0);
        chk("skip_total", 0, 32'(bus.o_beat_cnt), 2);

        // Write and start during RUN are dropped; rerun proves RAM intact.
        mdl[0] = rand_entry(0); mdl[0].cnt = 8'd3; cfg_write(0);
        run("busywr", 1, 2, 1'b0);
        run("rerun", 1, -1, 1'b0);

        // Random schedules with random stalls.
        for (int it = 0; it < 6; it++) begin
            for (int a = 0; a < 16; a++) begin
                mdl[a] = rand_entry(4);
                cfg_write(a);
            end
            for (int x = 0; x < MAXC; x++) stall_v[x] = ($urandom_range(0, 3) == 0);
            run("rand", $urandom_range(1, 20), -1, 1'b0);
            clear_stall();
        end

        // Asynchronous reset in the middle of a run.
        mdl[0] = rand_entry(0); mdl[0].cnt = 8'd6; cfg_write(0);
        bus.i_start = 1'b1;
        bus.i_num_entries = 5'd1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 chk_zero("arst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("arst_nodone", c, 32'(bus.o_done), 0);
            chk("arst_idle", c, 32'(bus.o_busy), 0);
        end
        @(posedge clk); #1;
        run("restart", 1, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
